wts_ocm_bus_bridge: RTL and testbench

//  Parametrised host-bus bridge between the OCM slot bus (req/ack) and a wts_core instance plus external sound RAM.

---
 rtl/wts_ocm_bus_bridge_if.sv | 20 ++
 rtl/wts_ocm_bus_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_wts_ocm_bus_bridge.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/wts_ocm_bus_bridge_if.sv
// Host-side OCM slot bus: level request with a one-cycle ack and data in both directions.
interface wts_ocm_bus_bridge_if;
    logic        req;
    logic        wrt;
    logic [15:0] adr;
    logic [7:0]  dbo;
    logic [7:0]  dbi;
    logic        ack;
    logic        busy;

    modport master (
        output req, wrt, adr, dbo,
        input  dbi, ack, busy
    );

    modport slave (
        input  req, wrt, adr, dbo,
        output dbi, ack, busy
    );
endinterface

// File: rtl/wts_ocm_bus_bridge.sv
// Bridges OCM host cycles to a wts_core register file or its external sound RAM,
// and mixes, attenuates and left-justifies the core's audio samples.
module wts_ocm_bus_bridge #(
    parameter int RD_WAIT  = 10,
    parameter int RAM_WAIT = 1,
    parameter int CORE_W   = 12,
    parameter int OUT_W    = 15
) (
    input  logic                     clk21m,
    input  logic                     reset,
    wts_ocm_bus_bridge_if.slave      bus,
    input  logic                     sw_mono,
    input  logic [2:0]               att,
    output logic                     core_wrreq,
    output logic                     core_rdreq,
    output logic                     core_wr_active,
    output logic                     core_rd_active,
    output logic [14:0]              core_a,
    output logic [7:0]               core_d,
    input  logic [7:0]               core_q,
    input  logic                     core_mem_ncs,
    input  logic [7:0]               core_mem_a,
    input  logic signed [CORE_W-1:0] core_left,
    input  logic signed [CORE_W-1:0] core_right,
    output logic                     ramreq,
    output logic                     ramwrt,
    output logic [20:0]              ramadr,
    output logic [7:0]               ramdbo,
    input  logic [7:0]               ramdbi,
    output logic signed [OUT_W-1:0]  wavl,
    output logic signed [OUT_W-1:0]  wavr
);

    localparam logic [3:0] RD_WAIT_C  = 4'(RD_WAIT);
    localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);
    localparam int         PAD        = OUT_W - CORE_W - 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CWR  = 3'd1,
        CRD  = 3'd2,
        RAM  = 3'd3,
        ACK  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  dbi_q, dbi_d;
    logic        wrt_q, wrt_d;
    logic [14:0] adr_q, adr_d;
    logic [7:0]  dbo_q, dbo_d;
    logic        wrreq_q, wrreq_d;
    logic        rdreq_q, rdreq_d;
    logic        ramreq_q, ramreq_d;
    logic        wr_act_q, wr_act_d;
    logic        rd_act_q, rd_act_d;

    logic signed [CORE_W:0]  mix_l, mix_r;
    logic signed [OUT_W-1:0] wavl_q, wavl_d;
    logic signed [OUT_W-1:0] wavr_q, wavr_d;

    // Arithmetic attenuation followed by placing the sample at the top of the output word.
    function automatic logic signed [OUT_W-1:0] att_justify(
        input logic signed [CORE_W:0] s,
        input logic [2:0]             sh
    );
        logic signed [CORE_W:0]  y;
        logic signed [OUT_W-1:0] w;
        y = s >>> sh;
        w = OUT_W'(y);
        return w <<< PAD;
    endfunction

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            cnt_q    <= '0;
            dbi_q    <= '0;
            wrt_q    <= 1'b0;
            adr_q    <= '0;
            dbo_q    <= '0;
            wrreq_q  <= 1'b0;
            rdreq_q  <= 1'b0;
            ramreq_q <= 1'b0;
            wr_act_q <= 1'b0;
            rd_act_q <= 1'b0;
            wavl_q   <= '0;
            wavr_q   <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            cnt_q    <= cnt_d;
            dbi_q    <= dbi_d;
            wrt_q    <= wrt_d;
            adr_q    <= adr_d;
            dbo_q    <= dbo_d;
            wrreq_q  <= wrreq_d;
            rdreq_q  <= rdreq_d;
            ramreq_q <= ramreq_d;
            wr_act_q <= wr_act_d;
            rd_act_q <= rd_act_d;
            wavl_q   <= wavl_d;
            wavr_q   <= wavr_d;
        end
    end

    // req_q tracks the level every cycle, so a request held through a busy period never re-triggers.
    always_comb begin
        state_d  = state_q;
        req_d    = bus.req;
        cnt_d    = cnt_q;
        dbi_d    = dbi_q;
        wrt_d    = wrt_q;
        adr_d    = adr_q;
        dbo_d    = dbo_q;
        wrreq_d  = 1'b0;
        rdreq_d  = 1'b0;
        ramreq_d = 1'b0;
        wr_act_d = wr_act_q;
        rd_act_d = rd_act_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req && !req_q) begin
                    wrt_d = bus.wrt;
                    adr_d = bus.adr[14:0];
                    dbo_d = bus.dbo;
                    if (!core_mem_ncs) begin
                        state_d  = RAM;
                        ramreq_d = 1'b1;
                        cnt_d    = RAM_WAIT_C;
                    end else if (bus.wrt) begin
                        state_d  = CWR;
                        wrreq_d  = 1'b1;
                        wr_act_d = 1'b1;
                    end else begin
                        state_d  = CRD;
                        rdreq_d  = 1'b1;
                        rd_act_d = 1'b1;
                        cnt_d    = RD_WAIT_C;
                    end
                end
            end
            CWR: begin
                state_d = ACK;
            end
            CRD: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    dbi_d   = core_q;
                    state_d = ACK;
                end
            end
            RAM: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!wrt_q) begin
                        dbi_d = ramdbi;
                    end
                    state_d = ACK;
                end
            end
            ACK: begin
                wr_act_d = 1'b0;
                rd_act_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Mono sum is one bit wider than a sample, so it cannot overflow.
    always_comb begin
        mix_l = (CORE_W+1)'(core_left);
        mix_r = (CORE_W+1)'(core_right);
        if (sw_mono) begin
            mix_l = (CORE_W+1)'(core_left) + (CORE_W+1)'(core_right);
            mix_r = mix_l;
        end
        wavl_d = att_justify(mix_l, att);
        wavr_d = att_justify(mix_r, att);
    end

    assign bus.dbi        = dbi_q;
    assign bus.ack        = (state_q == ACK);
    assign bus.busy       = (state_q != IDLE);
    assign core_wrreq     = wrreq_q;
    assign core_rdreq     = rdreq_q;
    assign core_wr_active = wr_act_q;
    assign core_rd_active = rd_act_q;
    assign core_a         = adr_q;
    assign core_d         = dbo_q;
    assign ramreq         = ramreq_q;
    assign ramwrt         = wrt_q;
    assign ramadr         = {core_mem_a, adr_q[12:0]};
    assign ramdbo         = dbo_q;
    assign wavl           = wavl_q;
    assign wavr           = wavr_q;

endmodule

// File: tb/tb_wts_ocm_bus_bridge.sv
// Directed bench for wts_ocm_bus_bridge: core write/read, RAM read/write, busy-time edges,
// mid-transaction reset and the audio mix/attenuate path.
module tb_wts_ocm_bus_bridge;

    logic        clk21m = 1'b0;
    logic        reset;
    logic        sw_mono;
    logic [2:0]  att;
    logic        core_wrreq, core_rdreq, core_wr_active, core_rd_active;
    logic [14:0] core_a;
    logic [7:0]  core_d;
    logic [7:0]  core_q;
    logic        core_mem_ncs;
    logic [7:0]  core_mem_a;
    logic [11:0] core_left, core_right;
    logic        ramreq, ramwrt;
    logic [20:0] ramadr;
    logic [7:0]  ramdbo, ramdbi;
    logic [14:0] wavl, wavr;

    int n_checks = 0;
    int n_fail   = 0;

    int          ack_at, ack_cnt, wr_cnt, rd_cnt, ram_cnt;
    logic [7:0]  dbi_seen, core_d_seen;
    logic [14:0] core_a_seen;
    logic [20:0] ramadr_seen;
    logic        ramwrt_seen, wr_act_at_ack;
    logic [7:0]  ramdbo_seen;

    wts_ocm_bus_bridge_if bus ();

    wts_ocm_bus_bridge #(
        .RD_WAIT (10),
        .RAM_WAIT(1),
        .CORE_W  (12),
        .OUT_W   (15)
    ) dut (
        .clk21m        (clk21m),
        .reset         (reset),
        .bus           (bus),
        .sw_mono       (sw_mono),
        .att           (att),
        .core_wrreq    (core_wrreq),
        .core_rdreq    (core_rdreq),
        .core_wr_active(core_wr_active),
        .core_rd_active(core_rd_active),
        .core_a        (core_a),
        .core_d        (core_d),
        .core_q        (core_q),
        .core_mem_ncs  (core_mem_ncs),
        .core_mem_a    (core_mem_a),
        .core_left     (core_left),
        .core_right    (core_right),
        .ramreq        (ramreq),
        .ramwrt        (ramwrt),
        .ramadr        (ramadr),
        .ramdbo        (ramdbo),
        .ramdbi        (ramdbi),
        .wavl          (wavl),
        .wavr          (wavr)
    );

    always #5 clk21m = ~clk21m;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk21m);
        #1;
    endtask

    // Observe one edge-started transaction; req_hi_from > 0 re-raises req (while busy) at that cycle and holds it.
    task automatic run_txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                           input logic ncs, input int window, input int req_hi_from);
        bus.wrt = w;
        bus.adr = a;
        bus.dbo = d;
        core_mem_ncs = ncs;
        bus.req = 1'b1;
        ack_at = 0; ack_cnt = 0; wr_cnt = 0; rd_cnt = 0; ram_cnt = 0;
        for (int n = 1; n <= window; n++) begin
            step();
            if (n == 1) bus.req = 1'b0;
            if (req_hi_from > 0 && n == req_hi_from) bus.req = 1'b1;
            if (core_wrreq) begin
                wr_cnt++;
                core_d_seen = core_d;
                core_a_seen = core_a;
            end
            if (core_rdreq) rd_cnt++;
            if (ramreq) begin
                ram_cnt++;
                ramadr_seen = ramadr;
                ramwrt_seen = ramwrt;
                ramdbo_seen = ramdbo;
            end
            if (bus.ack) begin
                ack_cnt++;
                if (ack_at == 0) begin
                    ack_at        = n;
                    dbi_seen      = bus.dbi;
                    wr_act_at_ack = core_wr_active;
                end
            end
        end
        bus.req = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        bus.req = 1'b0; bus.wrt = 1'b0; bus.adr = '0; bus.dbo = '0;
        sw_mono = 1'b0; att = '0;
        core_q = '0; core_mem_ncs = 1'b1; core_mem_a = '0;
        core_left = '0; core_right = '0; ramdbi = '0;
        step();
        step();

        chk("rst_ack",    {31'b0, bus.ack},  32'h0);
        chk("rst_busy",   {31'b0, bus.busy}, 32'h0);
        chk("rst_dbi",    {24'b0, bus.dbi},  32'h0);
        chk("rst_ramreq", {31'b0, ramreq},   32'h0);
        chk("rst_core_a", {17'b0, core_a},   32'h0);
        chk("rst_wavl",   {17'b0, wavl},     32'h0);
        reset = 1'b0;
        step();

        run_txn(1'b1, 16'h9800, 8'h5A, 1'b1, 6, 0);
        chk("cwr_ack_at",   ack_at,  2);
        chk("cwr_ack_cnt",  ack_cnt, 1);
        chk("cwr_wrreq",    wr_cnt,  1);
        chk("cwr_core_d",   {24'b0, core_d_seen}, 32'h5A);
        chk("cwr_core_a",   {17'b0, core_a_seen}, 32'h1800);
        chk("cwr_act_ack",  {31'b0, wr_act_at_ack}, 32'h1);
        chk("cwr_act_done", {31'b0, core_wr_active}, 32'h0);
        chk("cwr_busy_end", {31'b0, bus.busy}, 32'h0);

        core_q = 8'hC3;
        run_txn(1'b0, 16'h9900, 8'h00, 1'b1, 14, 0);
        chk("crd_ack_at",  ack_at,  11);
        chk("crd_rdreq",   rd_cnt,  1);
        chk("crd_dbi",     {24'b0, dbi_seen}, 32'hC3);
        chk("crd_act_end", {31'b0, core_rd_active}, 32'h0);

        core_mem_a = 8'h12;
        ramdbi = 8'h77;
        run_txn(1'b0, 16'h1ABC, 8'h00, 1'b0, 5, 0);
        chk("ramrd_adr",    {11'b0, ramadr_seen}, 32'h25ABC);
        chk("ramrd_req",    ram_cnt, 1);
        chk("ramrd_wrt",    {31'b0, ramwrt_seen}, 32'h0);
        chk("ramrd_ack_at", ack_at,  2);
        chk("ramrd_dbi",    {24'b0, dbi_seen}, 32'h77);
        chk("ramrd_core",   wr_cnt + rd_cnt, 0);

        core_mem_a = 8'h01;
        ramdbi = 8'hEE;
        run_txn(1'b1, 16'h0123, 8'h3C, 1'b0, 5, 0);
        chk("ramwr_adr",    {11'b0, ramadr_seen}, 32'h02123);
        chk("ramwr_wrt",    {31'b0, ramwrt_seen}, 32'h1);
        chk("ramwr_dbo",    {24'b0, ramdbo_seen}, 32'h3C);
        chk("ramwr_ack_at", ack_at,  2);
        chk("ramwr_dbi",    {24'b0, dbi_seen}, 32'h77);

        core_q = 8'h4D;
        run_txn(1'b0, 16'h9901, 8'h00, 1'b1, 20, 4);
        chk("busy_edge_ack_cnt", ack_cnt, 1);
        chk("busy_edge_ack_at",  ack_at,  11);
        chk("busy_edge_rdreq",   rd_cnt,  1);
        chk("busy_edge_idle",    {31'b0, bus.busy}, 32'h0);
        step();
        step();

        core_q = 8'h99;
        bus.wrt = 1'b0; bus.adr = 16'h9A00; core_mem_ncs = 1'b1; bus.req = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step();
            if (n == 1) bus.req = 1'b0;
        end
        chk("rst_mid_busy_before", {31'b0, bus.busy}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy",   {31'b0, bus.busy},       32'h0);
        chk("rst_mid_active", {31'b0, core_rd_active}, 32'h0);
        chk("rst_mid_ack",    {31'b0, bus.ack},        32'h0);
        step();
        reset = 1'b0;
        ack_cnt = 0;
        for (int n = 1; n <= 14; n++) begin
            step();
            if (bus.ack) ack_cnt++;
        end
        chk("rst_mid_no_ack", ack_cnt, 0);
        run_txn(1'b1, 16'h9800, 8'hA5, 1'b1, 6, 0);
        chk("post_rst_ack_at", ack_at, 2);
        chk("post_rst_core_d", {24'b0, core_d_seen}, 32'hA5);

        sw_mono = 1'b1; att = 3'd0; core_left = 12'h7FF; core_right = 12'h7FF;
        step();
        chk("mono_max_l", {17'b0, wavl}, 32'h3FF8);
        chk("mono_max_r", {17'b0, wavr}, 32'h3FF8);

        sw_mono = 1'b0; att = 3'd1; core_left = 12'h800; core_right = 12'h123;
        step();
        chk("st_att1_l", {17'b0, wavl}, 32'h7000);
        chk("st_att1_r", {17'b0, wavr}, 32'h0244);

        sw_mono = 1'b1; att = 3'd7; core_left = 12'h800; core_right = 12'h800;
        step();
        chk("mono_min_att7_l", {17'b0, wavl}, 32'h7F80);
        chk("mono_min_att7_r", {17'b0, wavr}, 32'h7F80);

        sw_mono = 1'b0; att = 3'd7; core_left = 12'h005; core_right = 12'hFFF;
        step();
        chk("st_att7_l", {17'b0, wavl}, 32'h0000);
        chk("st_att7_r", {17'b0, wavr}, 32'h7FFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
